// File: rtl/btree_mux_pipe.sv
// Pipelined binary-tree priority mux: the highest-index set flag selects its leaf's data.
// Optional miss counter enabled by defining BTREE_MUX_PIPE_MISS_EN.

`ifndef RECT_COUNT
`define RECT_COUNT 8
`endif
`ifndef RECT_COUNT_WIDTH
`define RECT_COUNT_WIDTH 3
`endif

module btree_mux_pipe #(
    parameter int unsigned INPUT_COUNT = `RECT_COUNT,
    parameter int unsigned INPUT_WIDTH = `RECT_COUNT_WIDTH,
    parameter int unsigned REG_EVERY   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic [INPUT_COUNT-1:0] flags_in,
    input  logic [INPUT_WIDTH-1:0] data_in [INPUT_COUNT],
    output logic                   out_valid,
    output logic                   out_hit,
    output logic [INPUT_WIDTH-1:0] out_data
`ifdef BTREE_MUX_PIPE_MISS_EN
    ,
    output logic [15:0]            miss_count
`endif
);

    localparam int unsigned LEVELS = $clog2(INPUT_COUNT);

    if (INPUT_COUNT < 2 || (INPUT_COUNT & (INPUT_COUNT - 1)) != 0) begin : g_err_count
        $error("btree_mux_pipe: INPUT_COUNT must be a power of two >= 2");
    end
    if (REG_EVERY < 1 || REG_EVERY > LEVELS) begin : g_err_reg
        $error("btree_mux_pipe: REG_EVERY must lie in 1..LEVELS");
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned N      = INPUT_COUNT >> (k + 1);
        localparam bit          IsLast = (k == LEVELS - 1);
        localparam bit          IsReg  = IsLast ||
                                         (REG_EVERY != 0 && ((k + 1) % REG_EVERY) == 0);

        logic [2*N-1:0]         src_flag;
        logic [INPUT_WIDTH-1:0] src_data [2*N];
        logic                   src_valid;
        logic [N-1:0]           node_flag;
        logic [INPUT_WIDTH-1:0] node_data [N];
        logic [N-1:0]           lvl_flag;
        logic [INPUT_WIDTH-1:0] lvl_data [N];
        logic                   lvl_valid;

        if (k == 0) begin : g_src_in
            assign src_flag  = flags_in;
            assign src_data  = data_in;
            assign src_valid = in_valid;
        end else begin : g_src_prev
            assign src_flag  = g_lvl[k-1].lvl_flag;
            assign src_data  = g_lvl[k-1].lvl_data;
            assign src_valid = g_lvl[k-1].lvl_valid;
        end

        // Odd (higher-index) child wins whenever its flag is set.
        always_comb begin
            node_flag = '0;
            for (int i = 0; i < N; i++) begin
                node_flag[i] = src_flag[2*i+1] | src_flag[2*i];
                node_data[i] = src_flag[2*i+1] ? src_data[2*i+1] : src_data[2*i];
            end
        end

        if (IsReg) begin : g_reg
            logic [N-1:0]           flag_q, flag_d;
            logic [INPUT_WIDTH-1:0] data_q [N];
            logic [INPUT_WIDTH-1:0] data_d [N];
            logic                   valid_q, valid_d;

            always_comb begin
                flag_d  = flag_q;
                data_d  = data_q;
                valid_d = valid_q;
                if (enable) begin
                    flag_d  = node_flag;
                    valid_d = src_valid;
                    // Only the final stage zeroes data for a no-hit sample.
                    for (int i = 0; i < N; i++) begin
                        data_d[i] = (IsLast && !node_flag[i]) ? '0 : node_data[i];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    flag_q  <= '0;
                    valid_q <= 1'b0;
                    for (int i = 0; i < N; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    flag_q  <= flag_d;
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign lvl_flag  = flag_q;
            assign lvl_data  = data_q;
            assign lvl_valid = valid_q;
        end else begin : g_comb
            assign lvl_flag  = node_flag;
            assign lvl_data  = node_data;
            assign lvl_valid = src_valid;
        end
    end

    assign out_valid = g_lvl[LEVELS-1].lvl_valid;
    assign out_hit   = g_lvl[LEVELS-1].lvl_flag[0];
    assign out_data  = g_lvl[LEVELS-1].lvl_data[0];

`ifdef BTREE_MUX_PIPE_MISS_EN
    logic [15:0] miss_q, miss_d;

    // Counts on the edge that loads a valid no-hit sample into the output stage.
    always_comb begin
        miss_d = miss_q;
        if (enable && g_lvl[LEVELS-1].src_valid && !g_lvl[LEVELS-1].node_flag[0] &&
            miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_btree_mux_pipe.sv
// Scoreboard bench for btree_mux_pipe: DUT a is 8x3 (S=3), DUT b is 64x6 with REG_EVERY=3 (S=2).
// Miss-counter checks are compiled only when BTREE_MUX_PIPE_MISS_EN is defined.

module tb_btree_mux_pipe;

    typedef struct {
        logic        hit;
        logic [5:0]  data;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // DUT a
    logic       reset_a, enable_a, in_valid_a;
    logic [7:0] flags_a;
    logic [2:0] data_a [8];
    logic       out_valid_a, out_hit_a;
    logic [2:0] out_data_a;
    // DUT b
    logic        reset_b, enable_b, in_valid_b;
    logic [63:0] flags_b;
    logic [5:0]  data_b [64];
    logic        out_valid_b, out_hit_b;
    logic [5:0]  out_data_b;
`ifdef BTREE_MUX_PIPE_MISS_EN
    logic [15:0] miss_a, miss_b;
`endif

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned ena_cnt = 0;
    int unsigned enb_cnt = 0;

    btree_mux_pipe #(.INPUT_COUNT(8), .INPUT_WIDTH(3), .REG_EVERY(1)) u_dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .enable     (enable_a),
        .in_valid   (in_valid_a),
        .flags_in   (flags_a),
        .data_in    (data_a),
        .out_valid  (out_valid_a),
        .out_hit    (out_hit_a),
        .out_data   (out_data_a)
`ifdef BTREE_MUX_PIPE_MISS_EN
        ,
        .miss_count (miss_a)
`endif
    );

    btree_mux_pipe #(.INPUT_COUNT(64), .INPUT_WIDTH(6), .REG_EVERY(3)) u_dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .enable     (enable_b),
        .in_valid   (in_valid_b),
        .flags_in   (flags_b),
        .data_in    (data_b),
        .out_valid  (out_valid_b),
        .out_hit    (out_hit_b),
        .out_data   (out_data_b)
`ifdef BTREE_MUX_PIPE_MISS_EN
        ,
        .miss_count (miss_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan upward, so the last (highest) set flag wins; no hit gives 0.
    function automatic exp_t model_a(input logic [7:0] f);
        exp_t e;
        e.hit  = 1'b0;
        e.data = '0;
        e.due  = 0;
        for (int i = 0; i < 8; i++) begin
            if (f[i]) begin
                e.hit  = 1'b1;
                e.data = 6'(i);
            end
        end
        return e;
    endfunction

    function automatic exp_t model_b(input logic [63:0] f);
        exp_t e;
        e.hit  = 1'b0;
        e.data = '0;
        e.due  = 0;
        for (int i = 0; i < 64; i++) begin
            if (f[i]) begin
                e.hit  = 1'b1;
                e.data = 6'(i) ^ 6'h2A;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (enable_a && !reset_a) ena_cnt++;
        if (enable_b && !reset_b) enb_cnt++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && ena_cnt > qa[0].due) begin
            chk("a_missing_out", ena_cnt, qa[0].due);
            void'(qa.pop_front());
        end
        if (out_valid_a) begin
            if (qa.size() == 0) begin
                chk("a_spurious_valid", 32'(out_valid_a), 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_hit", 32'(out_hit_a), 32'(e.hit));
                chk("a_data", 32'(out_data_a), 32'(e.data));
                chk("a_latency", ena_cnt, e.due);
            end
        end
        if (qb.size() > 0 && enb_cnt > qb[0].due) begin
            chk("b_missing_out", enb_cnt, qb[0].due);
            void'(qb.pop_front());
        end
        if (out_valid_b) begin
            if (qb.size() == 0) begin
                chk("b_spurious_valid", 32'(out_valid_b), 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_hit", 32'(out_hit_b), 32'(e.hit));
                chk("b_data", 32'(out_data_b), 32'(e.data));
                chk("b_latency", enb_cnt, e.due);
            end
        end
    end

    // Drives one clock of DUT a at a falling edge; scoreboards samples that will be accepted.
    task automatic step_a(input logic [7:0] f, input logic v, input logic en);
        exp_t e;
        flags_a    = f;
        in_valid_a = v;
        enable_a   = en;
        if (v && en && !reset_a) begin
            e     = model_a(f);
            e.due = ena_cnt + 3;
            qa.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic step_b(input logic [63:0] f, input logic v);
        exp_t e;
        flags_b    = f;
        in_valid_b = v;
        if (v && enable_b && !reset_b) begin
            e     = model_b(f);
            e.due = enb_cnt + 2;
            qb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] rf;
`ifdef BTREE_MUX_PIPE_MISS_EN
        logic [15:0] m0;
`endif
        for (int i = 0; i < 8; i++) data_a[i] = 3'(i);
        for (int i = 0; i < 64; i++) data_b[i] = 6'(i) ^ 6'h2A;
        reset_a = 1'b1; enable_a = 1'b1; in_valid_a = 1'b1; flags_a = 8'hFF;
        reset_b = 1'b1; enable_b = 1'b1; in_valid_b = 1'b1; flags_b = '1;
        repeat (4) @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;

        chk("reset_out_valid", 32'(out_valid_a), 32'd0);
        chk("reset_out_hit", 32'(out_hit_a), 32'd0);
        chk("reset_out_data", 32'(out_data_a), 32'd0);
`ifdef BTREE_MUX_PIPE_MISS_EN
        chk("reset_miss", 32'(miss_a), 32'd0);
`endif

        // Single hit sample, then confirm the valid pulse is one clock wide.
        step_a(8'b0010_0100, 1'b1, 1'b1);
        repeat (3) step_a(8'h00, 1'b0, 1'b1);
        chk("t1_valid_drops", 32'(out_valid_a), 32'd0);

        // No-hit sample: zero data rather than leaf 0.
`ifdef BTREE_MUX_PIPE_MISS_EN
        m0 = miss_a;
`endif
        step_a(8'h00, 1'b1, 1'b1);
        repeat (2) step_a(8'h00, 1'b0, 1'b1);
        chk("t2_out_valid", 32'(out_valid_a), 32'd1);
        chk("t2_out_data", 32'(out_data_a), 32'd0);
`ifdef BTREE_MUX_PIPE_MISS_EN
        chk("t2_miss_inc", 32'(miss_a), 32'(m0) + 32'd1);
`endif
        step_a(8'h00, 1'b0, 1'b1);

        // Back-to-back samples.
        step_a(8'h01, 1'b1, 1'b1);
        step_a(8'h80, 1'b1, 1'b1);
        step_a(8'h0F, 1'b1, 1'b1);
        step_a(8'h00, 1'b0, 1'b1);
        chk("t3_first_valid", 32'(out_valid_a), 32'd1);
        repeat (4) step_a(8'h00, 1'b0, 1'b1);

        // Stall mid-flight; the pulse presented while stalled must be dropped.
        step_a(8'b0100_1001, 1'b1, 1'b1);
        step_a(8'h00, 1'b0, 1'b1);
        step_a(8'hFF, 1'b1, 1'b0);
        step_a(8'h00, 1'b0, 1'b0);
        chk("t4_stalled_hold", 32'(out_valid_a), 32'd0);
        step_a(8'h00, 1'b0, 1'b1);
        chk("t4_out_valid", 32'(out_valid_a), 32'd1);
        chk("t4_out_data", 32'(out_data_a), 32'd6);
        repeat (4) step_a(8'h00, 1'b0, 1'b1);

        // Reset with two samples in flight.
        step_a(8'h10, 1'b1, 1'b1);
        step_a(8'h20, 1'b1, 1'b1);
        reset_a = 1'b1;
        step_a(8'h00, 1'b0, 1'b1);
        qa.delete();
        chk("t5_rst_valid", 32'(out_valid_a), 32'd0);
        chk("t5_rst_hit", 32'(out_hit_a), 32'd0);
        chk("t5_rst_data", 32'(out_data_a), 32'd0);
        reset_a = 1'b0;
        repeat (5) step_a(8'h00, 1'b0, 1'b1);
        chk("t5_no_stale", 32'(out_valid_a), 32'd0);

        // Wide tree, grouped registers: random flags of varying density.
        for (int n = 0; n < 1000; n++) begin
            rf = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rf = rf >> $urandom_range(0, 64);
            else if ($urandom_range(0, 1) == 0) rf = 64'd1 << $urandom_range(0, 63);
            step_b(rf, ($urandom_range(0, 7) != 0));
        end
        repeat (4) step_b('0, 1'b0);

`ifdef BTREE_MUX_PIPE_MISS_EN
        for (int n = 0; n < 70000; n++) step_a(8'h00, 1'b1, 1'b1);
        repeat (4) step_a(8'h00, 1'b0, 1'b1);
        chk("t6_miss_saturate", 32'(miss_a), 32'h0000FFFF);
`endif

        repeat (4) @(negedge clk);
        chk("a_drained", qa.size(), 32'd0);
        chk("b_drained", qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
